// File: rtl/cabac_bit_feeder_if.sv
// Byte stream handshake, consume request and peek window shared by the
// CABAC bit feeder (slave) and the arithmetic decoder / byte source (master).
interface cabac_bit_feeder_if #(
    parameter int CNT_W = 6
) ();
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             consume_en;
    logic [2:0]       consume_bits;
    logic [7:0]       peek_bits;
    logic [CNT_W-1:0] bits_avail;
    logic             stall;

    modport master (
        output byte_data, byte_valid, consume_en, consume_bits,
        input  byte_ready, peek_bits, bits_avail, stall
    );

    modport slave (
        input  byte_data, byte_valid, consume_en, consume_bits,
        output byte_ready, peek_bits, bits_avail, stall
    );
endinterface

// File: rtl/cabac_bit_feeder.sv
// CABAC bitstream front end: MSB-first shift window fed by bytes, drained by
// the decoder's per-cycle bit usage, with the 16-bit initial m_value at slice start.
module cabac_bit_feeder #(
    parameter int WIN_W = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                flush,
    cabac_bit_feeder_if.slave   bus,
    output logic [15:0]         init_value,
    output logic                init_valid,
    output logic                underflow,
    output logic [31:0]         bits_consumed
);
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(WIN_W - 8);
    localparam logic [CNT_W-1:0] INIT_BITS = CNT_W'(16);
    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

    state_t             state_reg;
    logic [WIN_W-1:0]   win_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [15:0]        init_value_reg;
    logic               init_valid_reg;
    logic               underflow_reg;
    logic [31:0]        bits_consumed_reg;

    logic               accept;
    logic               consume_req;
    logic               consume_ok;
    logic               init_ready;
    logic [CNT_W-1:0]   cb_ext;
    logic [CNT_W-1:0]   k;
    logic [CNT_W-1:0]   cnt_after;
    logic [CNT_W-1:0]   cnt_next;
    logic [WIN_W-1:0]   byte_ext;
    logic [WIN_W-1:0]   win_next;

    assign init_ready  = (state_reg == FILL) && (cnt_reg >= INIT_BITS);
    // The FILL->RUN transition cycle repurposes the window, so no byte may land then.
    assign bus.byte_ready = (state_reg != IDLE) && (cnt_reg <= READY_MAX) && !init_ready;
    assign accept      = bus.byte_valid && bus.byte_ready;

    assign cb_ext      = CNT_W'(bus.consume_bits);
    assign consume_req = (state_reg == RUN) && bus.consume_en;
    assign consume_ok  = consume_req && (cb_ext <= cnt_reg);
    assign k           = consume_ok ? cb_ext : '0;
    assign cnt_after   = cnt_reg - k;

    // New byte lands directly below the bits still unread after this cycle's consume.
    assign byte_ext    = {bus.byte_data, {(WIN_W-8){1'b0}}} >> cnt_after;
    assign win_next    = (win_reg << k) | (accept ? byte_ext : '0);
    assign cnt_next    = cnt_after + (accept ? BYTE_BITS : '0);

    assign bus.peek_bits  = win_reg[WIN_W-1 -: 8];
    assign bus.bits_avail = cnt_reg;
    assign bus.stall      = (state_reg == RUN) && (cnt_reg < BYTE_BITS);
    assign init_value     = init_value_reg;
    assign init_valid     = init_valid_reg;
    assign underflow      = underflow_reg;
    assign bits_consumed  = bits_consumed_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            win_reg           <= '0;
            cnt_reg           <= '0;
            init_value_reg    <= '0;
            init_valid_reg    <= 1'b0;
            underflow_reg     <= 1'b0;
            bits_consumed_reg <= '0;
        end else if (flush) begin
            state_reg         <= IDLE;
            win_reg           <= '0;
            cnt_reg           <= '0;
            init_value_reg    <= '0;
            init_valid_reg    <= 1'b0;
            underflow_reg     <= 1'b0;
            bits_consumed_reg <= '0;
        end else begin
            init_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) state_reg <= FILL;
                end
                FILL: begin
                    if (init_ready) begin
                        init_value_reg <= win_reg[WIN_W-1 -: 16];
                        init_valid_reg <= 1'b1;
                        win_reg        <= win_reg << 16;
                        cnt_reg        <= cnt_reg - INIT_BITS;
                        state_reg      <= RUN;
                    end else if (accept) begin
                        win_reg <= win_next;
                        cnt_reg <= cnt_next;
                    end
                end
                RUN: begin
                    win_reg           <= win_next;
                    cnt_reg           <= cnt_next;
                    bits_consumed_reg <= bits_consumed_reg + 32'(k);
                    if (consume_req && !consume_ok) underflow_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cabac_bit_feeder.sv
// Randomised and directed bench for cabac_bit_feeder against a bit-queue model.
module tb_cabac_bit_feeder;
    localparam int WIN_W = 32;
    localparam int CNT_W = 6;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [15:0] init_value;
    logic        init_valid, underflow;
    logic [31:0] bits_consumed;

    cabac_bit_feeder_if #(.CNT_W(CNT_W)) bus ();

    cabac_bit_feeder #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flush         (flush),
        .bus           (bus),
        .init_value    (init_value),
        .init_valid    (init_valid),
        .underflow     (underflow),
        .bits_consumed (bits_consumed)
    );

    always #5 clk = ~clk;

    // Reference model: unread stream bits, oldest first.
    bit          mq[$];
    int          m_state;           // 0 idle, 1 fill, 2 run
    logic [31:0] m_consumed;
    bit          m_under;
    logic [15:0] m_init_value;
    bit          m_init_valid;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [7:0] m_peek();
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i < mq.size()) p[7-i] = mq[i];
        return p;
    endfunction

    function automatic bit m_ready();
        return (m_state != 0) && (mq.size() <= WIN_W - 8) && !(m_state == 1 && mq.size() >= 16);
    endfunction

    function automatic bit m_stall();
        return (m_state == 2) && (mq.size() < 8);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_consumed = '0; m_under = 0; m_init_value = '0; m_init_valid = 0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
    endtask

    // Called at posedge+1: drives one cycle of inputs, advances the model, returns at next posedge+1.
    task automatic drive_cycle(input bit s, input bit v, input logic [7:0] d,
                               input bit ce, input logic [2:0] cb, input bit fl, output bit acc);
        bit rdy;
        start = s; flush = fl;
        bus.byte_valid = v; bus.byte_data = d; bus.consume_en = ce; bus.consume_bits = cb;
        rdy = bus.byte_ready;
        acc = 0;
        m_init_valid = 0;
        if (fl) model_reset();
        else case (m_state)
            0: if (s) m_state = 1;
            1: begin
                if (mq.size() >= 16) begin
                    for (int i = 0; i < 16; i++) m_init_value[15-i] = mq.pop_front();
                    m_init_valid = 1;
                    m_state = 2;
                end else if (v && rdy) begin
                    push_byte(d); acc = 1;
                end
            end
            default: begin
                if (ce) begin
                    if (int'(cb) <= mq.size()) begin
                        for (int i = 0; i < int'(cb); i++) void'(mq.pop_front());
                        m_consumed += 32'(cb);
                    end else m_under = 1;
                end
                if (v && rdy) begin
                    push_byte(d); acc = 1;
                end
            end
        endcase
        @(posedge clk); #1;
        start = 0; flush = 0; bus.byte_valid = 0; bus.consume_en = 0;
    endtask

    task automatic test_reset();
        n_vec++; if (bus.peek_bits !== 8'h00) begin n_err++; $display("FAIL rst_peek: got %h want 00", bus.peek_bits); end
        n_vec++; if (bus.bits_avail !== '0) begin n_err++; $display("FAIL rst_avail: got %0d want 0", bus.bits_avail); end
        n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.byte_ready); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        n_vec++; if (init_valid !== 1'b0 || init_value !== 16'h0) begin n_err++; $display("FAIL rst_init: got %b/%h want 0/0000", init_valid, init_value); end
        n_vec++; if (underflow !== 1'b0 || bits_consumed !== 32'h0) begin n_err++; $display("FAIL rst_under_cons: got %b/%0d want 0/0", underflow, bits_consumed); end
    endtask

    task automatic test_init();
        bit acc;
        drive_cycle(1, 0, 8'h00, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'h8C, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'hD1, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'h5A, 0, 3'd0, 0, acc);
        n_vec++; if (acc) begin n_err++; $display("FAIL init_no_accept: got accepted want held"); end
        n_vec++; if (init_valid !== 1'b1) begin n_err++; $display("FAIL init_valid: got %b want 1", init_valid); end
        n_vec++; if (init_value !== 16'h8CD1 || init_value !== m_init_value) begin n_err++; $display("FAIL init_value: got %h want 8cd1", init_value); end
        drive_cycle(0, 1, 8'h5A, 0, 3'd0, 0, acc);
        n_vec++; if (init_valid !== 1'b0) begin n_err++; $display("FAIL init_pulse: got %b want 0", init_valid); end
        n_vec++; if (bus.peek_bits !== 8'h5A || bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL init_peek: got %h want 5a", bus.peek_bits); end
        n_vec++; if (bus.bits_avail !== CNT_W'(8)) begin n_err++; $display("FAIL init_avail: got %0d want 8", bus.bits_avail); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL init_stall: got %b want 0", bus.stall); end
    endtask

    task automatic test_consume_accept();
        bit acc;
        drive_cycle(0, 1, 8'hF0, 1, 3'd3, 0, acc);
        n_vec++; if (bus.peek_bits !== 8'hD7 || bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL ca_peek: got %h want d7", bus.peek_bits); end
        n_vec++; if (bus.bits_avail !== CNT_W'(13)) begin n_err++; $display("FAIL ca_avail: got %0d want 13", bus.bits_avail); end
        n_vec++; if (bits_consumed !== 32'd3) begin n_err++; $display("FAIL ca_consumed: got %0d want 3", bits_consumed); end
    endtask

    task automatic reach_run13();
        bit acc;
        drive_cycle(1, 0, 8'h00, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'h8C, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'hD1, 0, 3'd0, 0, acc);
        drive_cycle(0, 0, 8'h00, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'h5A, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'hF0, 1, 3'd3, 0, acc);
    endtask

    task automatic test_reset_mid_run();
        bit acc;
        reset = 1'b1;
        #1;
        model_reset();
        test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 1, 8'hA5, 0, 3'd0, 0, acc);
            n_vec++; if (bus.byte_ready !== 1'b0 || bus.bits_avail !== '0) begin n_err++; $display("FAIL idle_ready: got %b/%0d want 0/0", bus.byte_ready, bus.bits_avail); end
        end
        reach_run13();
        n_vec++; if (bus.bits_avail !== CNT_W'(13) || bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL restart: got %0d/%h want 13/%h", bus.bits_avail, bus.peek_bits, m_peek()); end
    endtask

    task automatic test_backpressure();
        bit acc;
        drive_cycle(0, 1, 8'hAB, 0, 3'd0, 0, acc);
        drive_cycle(0, 1, 8'hCD, 1, 3'd4, 0, acc);
        n_vec++; if (bus.bits_avail !== CNT_W'(25)) begin n_err++; $display("FAIL bp_avail25: got %0d want 25", bus.bits_avail); end
        n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready0: got %b want 0", bus.byte_ready); end
        drive_cycle(0, 1, 8'hEF, 0, 3'd0, 0, acc);
        n_vec++; if (bus.bits_avail !== CNT_W'(25) || bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL bp_hold: got %0d/%h want 25/%h", bus.bits_avail, bus.peek_bits, m_peek()); end
        drive_cycle(0, 1, 8'hEF, 1, 3'd2, 0, acc);
        n_vec++; if (bus.bits_avail !== CNT_W'(23)) begin n_err++; $display("FAIL bp_avail23: got %0d want 23", bus.bits_avail); end
        n_vec++; if (bus.byte_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", bus.byte_ready); end
        drive_cycle(0, 1, 8'hEF, 0, 3'd0, 0, acc);
        n_vec++; if (bus.bits_avail !== CNT_W'(31) || bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL bp_fill31: got %0d/%h want 31/%h", bus.bits_avail, bus.peek_bits, m_peek()); end
        n_vec++; if (bits_consumed !== m_consumed) begin n_err++; $display("FAIL bp_consumed: got %0d want %0d", bits_consumed, m_consumed); end
    endtask

    task automatic test_underflow();
        bit acc;
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 8'h00, 1, 3'd7, 0, acc);
        drive_cycle(0, 0, 8'h00, 1, 3'd1, 0, acc);
        n_vec++; if (bus.bits_avail !== CNT_W'(2) || bus.stall !== 1'b1) begin n_err++; $display("FAIL uf_pre: got %0d/%b want 2/1", bus.bits_avail, bus.stall); end
        n_vec++; if (bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL uf_peek_zero_fill: got %h want %h", bus.peek_bits, m_peek()); end
        drive_cycle(0, 0, 8'h00, 1, 3'd5, 0, acc);
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag: got %b want 1", underflow); end
        n_vec++; if (bus.bits_avail !== CNT_W'(2) || bus.stall !== 1'b1) begin n_err++; $display("FAIL uf_cnt: got %0d/%b want 2/1", bus.bits_avail, bus.stall); end
        n_vec++; if (bits_consumed !== m_consumed) begin n_err++; $display("FAIL uf_consumed: got %0d want %0d", bits_consumed, m_consumed); end
        drive_cycle(0, 0, 8'h00, 0, 3'd0, 0, acc);
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b want 1", underflow); end
        drive_cycle(0, 0, 8'h00, 0, 3'd0, 1, acc);
        n_vec++; if (underflow !== 1'b0 || bits_consumed !== 32'h0) begin n_err++; $display("FAIL fl_clear: got %b/%0d want 0/0", underflow, bits_consumed); end
        n_vec++; if (bus.bits_avail !== '0 || bus.byte_ready !== 1'b0 || bus.peek_bits !== 8'h00) begin n_err++; $display("FAIL fl_idle: got %0d/%b/%h want 0/0/00", bus.bits_avail, bus.byte_ready, bus.peek_bits); end
    endtask

    task automatic test_random();
        bit acc, v, ce;
        logic [7:0] d;
        logic [2:0] cb;
        drive_cycle(1, 0, 8'h00, 0, 3'd0, 0, acc);
        for (int i = 0; i < 10000; i++) begin
            v  = ($urandom_range(0, 99) < 70);
            d  = 8'($urandom);
            cb = 3'($urandom_range(0, 7));
            ce = (m_state == 2) ? (mq.size() >= 8 && $urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1;
            drive_cycle(0, v, d, ce, cb, 0, acc);
            n_vec++; if (bus.peek_bits !== m_peek()) begin n_err++; $display("FAIL rnd_peek[%0d]: got %h want %h", i, bus.peek_bits, m_peek()); end
            n_vec++; if (bus.bits_avail !== CNT_W'(mq.size())) begin n_err++; $display("FAIL rnd_avail[%0d]: got %0d want %0d", i, bus.bits_avail, mq.size()); end
            n_vec++; if (bits_consumed !== m_consumed) begin n_err++; $display("FAIL rnd_consumed[%0d]: got %0d want %0d", i, bits_consumed, m_consumed); end
            n_vec++; if (bus.stall !== m_stall() || bus.byte_ready !== m_ready()) begin n_err++; $display("FAIL rnd_stall_ready[%0d]: got %b/%b want %b/%b", i, bus.stall, bus.byte_ready, m_stall(), m_ready()); end
            n_vec++; if (underflow !== m_under || init_valid !== m_init_valid) begin n_err++; $display("FAIL rnd_uf_init[%0d]: got %b/%b want %b/%b", i, underflow, init_valid, m_under, m_init_valid); end
            if (m_init_valid) begin
                n_vec++; if (init_value !== m_init_value) begin n_err++; $display("FAIL rnd_init_value[%0d]: got %h want %h", i, init_value, m_init_value); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 0; flush = 0;
        bus.byte_valid = 0; bus.byte_data = '0; bus.consume_en = 0; bus.consume_bits = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_init();
        test_consume_accept();
        test_reset_mid_run();
        test_backpressure();
        test_underflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
